ox_board_writer: RTL and testbench

- Sequential producer for the tic-tac-toe line checker. It collects alternating O/X moves one cell at a time and tracks occupancy.
- When the board is complete, it emits the packed 9-bit board rotated into the checker's {Sequence, Original_pos} format.
- It sits upstream of the checker, which de-rotates the packed board and counts lines. Together the two blocks form the write and read ends of one board encoding.

---
 rtl/ox_board_writer.sv | 169 ++++++++++++++++
 tb/tb_ox_board_writer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ox_board_writer.sv
// rtl/ox_board_writer.sv - collects alternating O/X moves and emits the rotated board
// Optional OX_WRITER_EARLY_END_EN: end the game as soon as any line is complete.
module ox_board_writer #(
    parameter bit FIRST_PLAYER = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic [3:0] start_pos,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_pos,
    output logic       move_err,
    output logic [3:0] move_cnt,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [8:0] Sequence,
    output logic [3:0] Original_pos,
    output logic [8:0] out_mask
);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t     state_q, state_d;
    logic [8:0] board_q, board_d;
    logic [8:0] occ_q, occ_d;
    logic       turn_q, turn_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] orig_q, orig_d;
    logic [8:0] seq_q, seq_d;
    logic [8:0] mask_q, mask_d;
    logic       in_ready_q, in_ready_d;
    logic       out_valid_q, out_valid_d;
    logic       move_err_q, move_err_d;

    logic       pos_ok, start_ok, legal, line_hit;
    logic [8:0] cell_oh;

    // The doubled word turns a right shift into a 9-bit rotation.
    function automatic logic [8:0] rot_r(input logic [8:0] x, input logic [3:0] k);
        logic [17:0] d;
        d = {x, x} >> (k - 4'd1);
        return d[8:0];
    endfunction

`ifdef OX_WRITER_EARLY_END_EN
    function automatic logic has_line(input logic [8:0] b, input logic [8:0] o);
        logic [8:0] lines [8];
        logic       hit;
        lines = '{9'h007, 9'h038, 9'h1C0, 9'h049, 9'h092, 9'h124, 9'h111, 9'h054};
        hit = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if ((o & lines[i]) == lines[i] &&
                ((b & lines[i]) == lines[i] || (b & lines[i]) == 9'd0))
                hit = 1'b1;
        end
        return hit;
    endfunction
`endif

    always_comb begin
        state_d     = state_q;
        board_d     = board_q;
        occ_d       = occ_q;
        turn_d      = turn_q;
        cnt_d       = cnt_q;
        orig_d      = orig_q;
        seq_d       = seq_q;
        mask_d      = mask_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        move_err_d  = 1'b0;
        line_hit    = 1'b0;

        pos_ok   = (in_pos >= 4'd1) && (in_pos <= 4'd9);
        cell_oh  = pos_ok ? (9'd1 << (in_pos - 4'd1)) : 9'd0;
        start_ok = (state_q != IDLE) || ((start_pos >= 4'd1) && (start_pos <= 4'd9));
        legal    = pos_ok && ((occ_q & cell_oh) == 9'd0) && start_ok;

        if (clear) begin
            state_d     = IDLE;
            board_d     = 9'd0;
            occ_d       = 9'd0;
            turn_d      = FIRST_PLAYER;
            cnt_d       = 4'd0;
            orig_d      = 4'd0;
            seq_d       = 9'd0;
            mask_d      = 9'd0;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
        end else if (state_q == DONE) begin
            if (out_valid_q && out_ready) begin
                state_d     = IDLE;
                board_d     = 9'd0;
                occ_d       = 9'd0;
                turn_d      = FIRST_PLAYER;
                cnt_d       = 4'd0;
                orig_d      = 4'd0;
                seq_d       = 9'd0;
                mask_d      = 9'd0;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        end else begin
            in_ready_d = 1'b1;
            if (in_valid && in_ready_q) begin
                if (legal) begin
                    board_d = turn_q ? (board_q | cell_oh) : (board_q & ~cell_oh);
                    occ_d   = occ_q | cell_oh;
                    turn_d  = ~turn_q;
                    cnt_d   = cnt_q + 4'd1;
                    if (state_q == IDLE)
                        orig_d = start_pos;
`ifdef OX_WRITER_EARLY_END_EN
                    line_hit = has_line(board_d, occ_d);
`endif
                    if (cnt_d == 4'd9 || line_hit) begin
                        state_d     = DONE;
                        in_ready_d  = 1'b0;
                        out_valid_d = 1'b1;
                        seq_d       = rot_r(board_d, orig_d);
                        mask_d      = rot_r(occ_d, orig_d);
                    end else begin
                        state_d = FILL;
                    end
                end else begin
                    move_err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            board_q     <= 9'd0;
            occ_q       <= 9'd0;
            turn_q      <= FIRST_PLAYER;
            cnt_q       <= 4'd0;
            orig_q      <= 4'd0;
            seq_q       <= 9'd0;
            mask_q      <= 9'd0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            move_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            board_q     <= board_d;
            occ_q       <= occ_d;
            turn_q      <= turn_d;
            cnt_q       <= cnt_d;
            orig_q      <= orig_d;
            seq_q       <= seq_d;
            mask_q      <= mask_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            move_err_q  <= move_err_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign move_err     = move_err_q;
    assign move_cnt     = cnt_q;
    assign out_valid    = out_valid_q;
    assign Sequence     = seq_q;
    assign Original_pos = orig_q;
    assign out_mask     = mask_q;

endmodule

// File: tb/tb_ox_board_writer.sv
// tb/tb_ox_board_writer.sv - directed-vector bench for ox_board_writer
module tb_ox_board_writer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] start_pos = 4'd1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_pos = 4'd0;
    logic       move_err;
    logic [3:0] move_cnt;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [8:0] Sequence;
    logic [3:0] Original_pos;
    logic [8:0] out_mask;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef OX_WRITER_EARLY_END_EN
    // Diagonal 3-5-7 of O completes on move 7 of the 1..9 game.
    localparam logic [8:0] SEQ_A  = 9'h02A;
    localparam logic [8:0] MASK_A = 9'h07F;
    localparam logic [3:0] CNT_A  = 4'd7;
    localparam logic [8:0] SEQ_B  = 9'h015;
    localparam logic [8:0] MASK_B = 9'h13F;
`else
    localparam logic [8:0] SEQ_A  = 9'h0AA;
    localparam logic [8:0] MASK_A = 9'h1FF;
    localparam logic [3:0] CNT_A  = 4'd9;
    localparam logic [8:0] SEQ_B  = 9'h055;
    localparam logic [8:0] MASK_B = 9'h1FF;
`endif

    ox_board_writer #(.FIRST_PLAYER(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .start_pos(start_pos),
        .in_valid(in_valid), .in_ready(in_ready), .in_pos(in_pos),
        .move_err(move_err), .move_cnt(move_cnt), .out_valid(out_valid),
        .out_ready(out_ready), .Sequence(Sequence), .Original_pos(Original_pos),
        .out_mask(out_mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] rot_l(input logic [8:0] x, input logic [3:0] k);
        logic [17:0] d;
        d = {x, x} << (k - 4'd1);
        return d[17:9];
    endfunction

    task automatic do_move(input logic [3:0] pos, input logic [3:0] sp);
        @(negedge clk);
        in_valid  = 1'b1;
        in_pos    = pos;
        start_pos = sp;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("hs_valid", out_valid, 0);
        check("hs_cnt", move_cnt, 0);
        check("hs_ready", in_ready, 1);
    endtask

    task automatic play_full(input logic [3:0] sp, input logic [8:0] es, input logic [8:0] em,
                             input string tag);
        for (int i = 1; i <= 9; i++) begin
            if (i == 9) check({tag, "_pre_valid"}, out_valid, CNT_A == 4'd9 ? 0 : 1);
            do_move(i[3:0], sp);
        end
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_seq"}, Sequence, es);
        check({tag, "_orig"}, Original_pos, sp);
        check({tag, "_mask"}, out_mask, em);
        check({tag, "_cnt"}, move_cnt, CNT_A);
        check({tag, "_err"}, move_err, 0);
    endtask

    initial begin
        logic [8:0] held;
        int         budget;

        // Reset
        #12;
        check("rst_outs", {in_ready, move_err, move_cnt, out_valid, Sequence, Original_pos, out_mask}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_ready_pre", in_ready, 0);
        @(posedge clk);
        #1;
        check("rst_ready_post", in_ready, 1);

        // Game A, with a stalled consumer and in_valid held high in DONE
        play_full(4'd1, SEQ_A, MASK_A, "gameA");
        held = Sequence;
        @(negedge clk);
        in_valid = 1'b1;
        in_pos   = 4'd3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", out_valid, 1);
            check("stall_seq", Sequence, held);
            check("stall_err", move_err, 0);
            check("stall_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        handshake();

        // Game B, rotated start; checker de-rotation must return the board
        play_full(4'd2, SEQ_B, MASK_B, "gameB");
        check("derot_seq", rot_l(Sequence, Original_pos), SEQ_A);
        check("derot_mask", rot_l(out_mask, Original_pos), MASK_A);
        handshake();

        // Illegal moves
        do_move(4'd5, 4'd1);
        check("ill_first_err", move_err, 0);
        do_move(4'd5, 4'd1);
        check("ill_dup_err", move_err, 1);
        @(negedge clk);
        check("ill_pulse_len", move_err, 0);
        do_move(4'd0, 4'd1);
        check("ill_zero_err", move_err, 1);
        do_move(4'd12, 4'd1);
        check("ill_big_err", move_err, 1);
        check("ill_cnt", move_cnt, 1);
        // Remaining moves: X at 1, then alternating through 2,3,4,6,7,8,9
        do_move(4'd1, 4'd1);
        do_move(4'd2, 4'd1);
        do_move(4'd3, 4'd1);
        do_move(4'd4, 4'd1);
        do_move(4'd6, 4'd1);
        do_move(4'd7, 4'd1);
        do_move(4'd8, 4'd1);
        do_move(4'd9, 4'd1);
        check("ill_game_valid", out_valid, 1);
        check("ill_game_seq", Sequence, 9'h0A5);
        check("ill_game_cnt", move_cnt, 9);
        handshake();

        // Bad start_pos on first move
        do_move(4'd1, 4'd0);
        check("bad_start_err", move_err, 1);
        check("bad_start_cnt", move_cnt, 0);

        // clear after 4 moves
        for (int i = 1; i <= 4; i++) do_move(i[3:0], 4'd3);
        check("pre_clear_cnt", move_cnt, 4);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear_outs", {move_err, move_cnt, out_valid, Sequence, Original_pos, out_mask}, 0);
        play_full(4'd1, SEQ_A, MASK_A, "after_clear");
        handshake();

        // Asynchronous reset mid-cycle after 6 moves
        for (int i = 1; i <= 6; i++) do_move(i[3:0], 4'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_outs", {in_ready, move_err, move_cnt, out_valid, Sequence, Original_pos, out_mask}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        budget = 0;
        while (!in_ready && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        check("async_ready_back", in_ready, 1);
        play_full(4'd1, SEQ_A, MASK_A, "after_rst");
        handshake();

`ifdef OX_WRITER_EARLY_END_EN
        do_move(4'd1, 4'd1);
        do_move(4'd4, 4'd1);
        do_move(4'd2, 4'd1);
        do_move(4'd5, 4'd1);
        check("early_pre_valid", out_valid, 0);
        do_move(4'd3, 4'd1);
        check("early_valid", out_valid, 1);
        check("early_seq", Sequence, 9'h018);
        check("early_mask", out_mask, 9'h01F);
        check("early_cnt", move_cnt, 5);
        handshake();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
